// File: rtl/instr_encode_loader_pkg.sv
// Shared definitions for the MIPS-32 instruction encoder/loader: opcodes,
// field widths and bit positions (common with the fetch-side decoder), FSM states.
package instr_encode_loader_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int JADDR_W  = 26;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;
    localparam int JADDR_LSB  = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/instr_encode_loader_if.sv
// Field-tuple input, instruction-memory write port and session status of the loader.
interface instr_encode_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_opcode;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_immediate;
    logic [25:0]       in_address;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              busy;
    logic              done;
    logic              full_err;
    logic [ADDR_W:0]   count;

    // Harness / boot source together with the memory it loads.
    modport master (
        output start, in_valid, in_opcode, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_immediate, in_address, in_last, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, full_err, count
    );

    // The loader itself.
    modport slave (
        input  start, in_valid, in_opcode, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_immediate, in_address, in_last, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, full_err, count
    );
endinterface

// File: rtl/instr_field_packer.sv
// Combinational packer: decoded MIPS-32 field tuple -> R/I/J-format word.
module instr_field_packer
    import instr_encode_loader_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] immediate,
    input  logic [25:0] address,
    output logic [31:0] word
);
    always_comb begin
        word = '0;
        word[OPCODE_LSB +: OPCODE_W] = opcode;
        case (opcode)
            OP_RTYPE: begin
                word[RS_LSB    +: REG_W]   = rs;
                word[RT_LSB    +: REG_W]   = rt;
                word[RD_LSB    +: REG_W]   = rd;
                word[SHAMT_LSB +: SHAMT_W] = shamt;
                word[FUNCT_LSB +: FUNCT_W] = funct;
            end
            OP_J, OP_JAL: begin
                word[JADDR_LSB +: JADDR_W] = address;
            end
            default: begin
                word[RS_LSB  +: REG_W] = rs;
                word[RT_LSB  +: REG_W] = rt;
                word[IMM_LSB +: IMM_W] = immediate;
            end
        endcase
    end
endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: encodes one field tuple per handshake and writes it to the
// next instruction-memory word, reporting completion or overflow.
module instr_encode_loader
    import instr_encode_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_encode_loader_if.slave  bus
);
    logic [31:0] enc_word;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              full_err_q, full_err_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              at_max;

    instr_field_packer u_packer (
        .opcode    (bus.in_opcode),
        .rs        (bus.in_rs),
        .rt        (bus.in_rt),
        .rd        (bus.in_rd),
        .shamt     (bus.in_shamt),
        .funct     (bus.in_funct),
        .immediate (bus.in_immediate),
        .address   (bus.in_address),
        .word      (enc_word)
    );

    assign at_max = (addr_q == {ADDR_W{1'b1}});

    // Outputs are computed one cycle ahead so that every status/handshake
    // output comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wdata_d    = wdata_q;
        last_d     = last_q;
        full_err_d = full_err_q;
        in_ready_d = in_ready_q;
        mem_we_d   = mem_we_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_LOAD;
                    addr_d     = '0;
                    count_d    = '0;
                    full_err_d = 1'b0;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    state_d    = S_WRITE;
                    wdata_d    = enc_word;
                    last_d     = bus.in_last;
                    in_ready_d = 1'b0;
                    mem_we_d   = 1'b1;
                end
            end
            S_WRITE: begin
                if (bus.mem_ready) begin
                    mem_we_d = 1'b0;
                    count_d  = count_q + (ADDR_W+1)'(1);
                    // The pointer saturates at the top word instead of wrapping.
                    if (!at_max) addr_d = addr_q + ADDR_W'(1);
                    if (last_q || at_max) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        if (!last_q) full_err_d = 1'b1;
                    end else begin
                        state_d    = S_LOAD;
                        in_ready_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b0;
                mem_we_d   = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            wdata_q    <= '0;
            last_q     <= 1'b0;
            full_err_q <= 1'b0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wdata_q    <= wdata_d;
            last_q     <= last_d;
            full_err_q <= full_err_d;
            in_ready_q <= in_ready_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.full_err  = full_err_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: an ADDR_W=8 instance for encoding,
// stall and reset cases, and an ADDR_W=2 instance for overflow.
module tb_instr_encode_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instr_encode_loader_if #(.ADDR_W(8)) bus8 ();
    instr_encode_loader_if #(.ADDR_W(2)) bus2 ();

    instr_encode_loader #(.ADDR_W(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
    instr_encode_loader #(.ADDR_W(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set8(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [25:0] adr, input logic last);
        bus8.in_opcode    = op;
        bus8.in_rs        = rs;
        bus8.in_rt        = rt;
        bus8.in_rd        = rd;
        bus8.in_shamt     = sh;
        bus8.in_funct     = fn;
        bus8.in_immediate = imm;
        bus8.in_address   = adr;
        bus8.in_last      = last;
    endtask

    task automatic start8();
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus8.start = 0; bus8.in_valid = 0; bus8.mem_ready = 1;
        set8(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus2.start = 0; bus2.in_valid = 0; bus2.mem_ready = 1;
        bus2.in_opcode = 0; bus2.in_rs = 0; bus2.in_rt = 0; bus2.in_rd = 0;
        bus2.in_shamt = 0; bus2.in_funct = 0; bus2.in_immediate = 0;
        bus2.in_address = 0; bus2.in_last = 0;

        tick();
        tick();
        check("rst_in_ready", bus8.in_ready, 0);
        check("rst_mem_we",   bus8.mem_we, 0);
        check("rst_busy",     bus8.busy, 0);
        check("rst_done",     bus8.done, 0);
        check("rst_full_err", bus8.full_err, 0);
        check("rst_addr",     bus8.mem_addr, 0);
        check("rst_wdata",    bus8.mem_wdata, 0);
        check("rst_count",    bus8.count, 0);
        reset = 1'b0;
        tick();

        // R-type add $3,$1,$2
        start8();
        check("r_in_ready", bus8.in_ready, 1);
        check("r_busy", bus8.busy, 1);
        set8(6'b000000, 1, 2, 3, 0, 6'b100000, 16'hFFFF, 26'h3FFFFFF, 1);
        bus8.in_valid = 1;
        tick();
        bus8.in_valid = 0;
        check("r_mem_we", bus8.mem_we, 1);
        check("r_in_ready_wr", bus8.in_ready, 0);
        check("r_addr", bus8.mem_addr, 0);
        check("r_wdata", bus8.mem_wdata, 32'h00221820);
        tick();
        check("r_done", bus8.done, 1);
        check("r_busy_done", bus8.busy, 0);
        check("r_we_off", bus8.mem_we, 0);
        check("r_count", bus8.count, 1);
        tick();
        check("r_done_pulse", bus8.done, 0);
        check("r_count_hold", bus8.count, 1);

        // I-type addi $8,$0,5 then J 0x10; unused fields carry junk
        start8();
        set8(6'b001000, 0, 8, 31, 31, 6'h3F, 16'h0005, 26'h3FFFFFF, 0);
        bus8.in_valid = 1;
        tick();
        bus8.in_valid = 0;
        check("i_addr", bus8.mem_addr, 0);
        check("i_wdata", bus8.mem_wdata, 32'h20080005);
        tick();
        check("i_back_load", bus8.in_ready, 1);
        check("i_we_off", bus8.mem_we, 0);
        set8(6'b000010, 31, 31, 31, 31, 6'h3F, 16'hFFFF, 26'h0000010, 1);
        bus8.in_valid = 1;
        tick();
        bus8.in_valid = 0;
        check("j_addr", bus8.mem_addr, 1);
        check("j_wdata", bus8.mem_wdata, 32'h08000010);
        tick();
        check("j_done", bus8.done, 1);
        check("j_count", bus8.count, 2);
        tick();

        // JAL write held off by mem_ready=0 for 5 cycles; a stray tuple is ignored
        bus8.mem_ready = 0;
        start8();
        set8(6'b000011, 0, 0, 0, 0, 0, 0, 26'h3FFFFFF, 1);
        bus8.in_valid = 1;
        tick();
        set8(6'b001000, 1, 1, 1, 1, 1, 16'h1234, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_we", i), bus8.mem_we, 1);
            check($sformatf("stall%0d_addr", i), bus8.mem_addr, 0);
            check($sformatf("stall%0d_wdata", i), bus8.mem_wdata, 32'h0FFFFFFF);
            check($sformatf("stall%0d_in_ready", i), bus8.in_ready, 0);
            tick();
        end
        bus8.in_valid = 0;
        check("stall_done_pre", bus8.done, 0);
        bus8.mem_ready = 1;
        tick();
        check("stall_done", bus8.done, 1);
        check("stall_count", bus8.count, 1);
        tick();

        // lw $9,-4($29) stuck in WRITE, then asynchronous reset
        bus8.mem_ready = 0;
        start8();
        set8(6'b100011, 29, 9, 0, 0, 0, 16'hFFFC, 0, 0);
        bus8.in_valid = 1;
        tick();
        bus8.in_valid = 0;
        check("lw_wdata", bus8.mem_wdata, 32'h8FA9FFFC);
        check("lw_we", bus8.mem_we, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_mem_we", bus8.mem_we, 0);
        check("arst_busy", bus8.busy, 0);
        check("arst_in_ready", bus8.in_ready, 0);
        check("arst_wdata", bus8.mem_wdata, 0);
        check("arst_addr", bus8.mem_addr, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        bus8.mem_ready = 1;

        // start during LOAD must not rewind the pointer
        start8();
        bus8.in_valid = 1;
        tick();
        bus8.in_valid = 0;
        tick();
        check("sb_addr_pre", bus8.mem_addr, 1);
        start8();
        check("sb_addr", bus8.mem_addr, 1);
        check("sb_count", bus8.count, 1);
        check("sb_in_ready", bus8.in_ready, 1);
        set8(6'b000000, 1, 2, 3, 0, 6'b100000, 0, 0, 1);
        bus8.in_valid = 1;
        tick();
        bus8.in_valid = 0;
        check("sb_addr_wr", bus8.mem_addr, 1);
        check("sb_wdata", bus8.mem_wdata, 32'h00221820);
        tick();
        check("sb_done", bus8.done, 1);
        check("sb_count_final", bus8.count, 2);
        tick();

        // Overflow on a 4-word memory
        bus2.start = 1;
        tick();
        bus2.start = 0;
        for (int i = 0; i < 4; i++) begin
            bus2.in_opcode = 6'b001000;
            bus2.in_rt = 5'(i);
            bus2.in_immediate = 16'(i);
            bus2.in_valid = 1;
            tick();
            bus2.in_valid = 0;
            check($sformatf("ovf%0d_addr", i), bus2.mem_addr, i);
            check($sformatf("ovf%0d_wdata", i), bus2.mem_wdata, 32'h20000000 | (i << 16) | i);
            tick();
            if (i < 3) begin
                check($sformatf("ovf%0d_full_err", i), bus2.full_err, 0);
                check($sformatf("ovf%0d_in_ready", i), bus2.in_ready, 1);
            end
        end
        check("ovf_done", bus2.done, 1);
        check("ovf_full_err", bus2.full_err, 1);
        check("ovf_count", bus2.count, 4);
        check("ovf_addr_nowrap", bus2.mem_addr, 3);
        tick();
        check("ovf_done_pulse", bus2.done, 0);
        check("ovf_full_err_sticky", bus2.full_err, 1);
        bus2.start = 1;
        tick();
        bus2.start = 0;
        check("ovf_clear_full_err", bus2.full_err, 0);
        check("ovf_clear_count", bus2.count, 0);
        check("ovf_clear_addr", bus2.mem_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_encode_loader.md
# instr_encode_loader

Packs decoded MIPS-32 instruction fields into R-, I- or J-format 32-bit words and writes them sequentially into instruction memory. It is the inverse of the fetch-side field splitter and serves as the program loader for the single-cycle core. A test harness or boot source supplies one field tuple per handshake. The block encodes it, writes it at the next word address, and reports completion or overflow.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width; depth = 2^ADDR_W words

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a load session at word address 0; ignored unless idle
- in_valid  in  1  field tuple valid
- in_ready  out  1  block accepts a tuple this cycle
- in_opcode  in  6  opcode field
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_shamt  in  5  shift amount (R-type)
- in_funct  in  6  function field (R-type)
- in_immediate  in  16  immediate (I-type)
- in_address  in  26  jump target (J-type)
- in_last  in  1  marks the final tuple of the session
- mem_we  out  1  write request to instruction memory
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts the write this cycle
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at end of session
- full_err  out  1  sticky; memory filled before in_last; cleared by next accepted start
- count  out  ADDR_W+1  words written this session

## Operation
- Encoding, selected on in_opcode:
  - 000000 (R-type): {opcode, rs, rt, rd, shamt, funct}.
  - 000010 or 000011 (J-type): {opcode, address}.
  - Every other opcode (I-type): {opcode, rs, rt, immediate}.
  - Fields not used by the selected format are ignored.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE: busy=0, in_ready=0.
  - On start: clear the address pointer, count and full_err, then go to LOAD.
- LOAD: busy=1, in_ready=1.
  - On in_valid: register the encoded word and in_last, then go to WRITE.
- WRITE: in_ready=0. mem_we=1, with mem_addr and mem_wdata held stable until mem_ready.
  - On mem_ready: increment the pointer and count.
  - If the stored last flag is set, go to DONE.
  - Else if the pointer was 2^ADDR_W−1, set full_err and go to DONE.
  - Else go back to LOAD.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- start is ignored in every state except IDLE.
- in_valid is ignored outside LOAD.
- mem_addr never wraps. After a full session, count = 2^ADDR_W.

## Timing
- Reset values: state IDLE; in_ready, mem_we, busy, done, full_err all 0; mem_addr, mem_wdata, count all 0.
- reset asserted mid-session forces all of the above immediately, asynchronously. Any pending write is abandoned, and the memory sees mem_we drop the same instant.
- start sampled at edge N makes in_ready=1 at N+1.
- A tuple accepted at edge N drives mem_we=1 with the encoded word from N+1.
- With mem_ready tied high, throughput is 1 word per 2 cycles.
- In the cycle after the final write completes: done=1 and count holds its final value. count and full_err remain valid until the next start.
- mem_ready low stalls in WRITE indefinitely, with no change on any output.

## Structure
- Shared package holds:
  - Opcode constants OP_RTYPE=6'b000000, OP_J=6'b000010, OP_JAL=6'b000011.
  - The FSM state encoding.
  - Field bit-position constants, shared with the decoder so both agree.
- One natural sub-module: instr_field_packer, a purely combinational tuple→32-bit encoder. It is reusable by the testbench to build expected words.

## Test plan
- R-type: start; tuple op=000000, rs=1, rt=2, rd=3, shamt=0, funct=100000, in_last=1 → mem_wdata=0x00221820 at mem_addr 0; done pulse; count=1.
- I-type then J-type: tuple op=001000, rs=0, rt=8, imm=0x0005, then op=000010, address=0x0000010 with last → writes 0x20080005 at address 0 and 0x08000010 at address 1; count=2.
- Memory stall: hold mem_ready=0 for 5 cycles during WRITE → mem_we, mem_addr and mem_wdata stay constant and in_ready stays 0; the write completes on the first mem_ready=1.
- Overflow with ADDR_W=2: four tuples, none marked last → writes at addresses 0..3, then full_err=1, done pulse, count=4; the next start clears full_err.
- Reset mid-WRITE and start-while-busy: assert reset while mem_we=1 → all outputs 0 immediately. After release, a start pulse while in LOAD is ignored and mem_addr is not reset to 0.
